drm_sdpram_be: RTL and testbench

Parametrised single-clock simple dual-port RAM: the next generation of the fixed-geometry DRM wrappers. Adds configurable width and depth, per-byte write enables, a read enable with `rd_valid` tracking, an optional output register stage and a selectable read-during-write collision mode. It sits beside the DRM wrappers as the storage primitive for line buffers and FIFOs that need byte-granular updates and known read latency.

---
 rtl/drm_sdpram_be.sv | 127 ++++++++++++
 tb/tb_drm_sdpram_be.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/drm_sdpram_be.sv
// -----------------------------------------------------------------------------
// drm_sdpram_be
//   Single-clock simple dual-port RAM with per-byte write enables, a read
//   enable with rd_valid tracking, an optional output register stage and a
//   selectable read-during-write collision mode.
//
// Parameters
//   ADDR_WIDTH     address bits, depth = 2**ADDR_WIDTH words (4..16)
//   DATA_WIDTH     word width, integer multiple of BYTE_SIZE
//   BYTE_SIZE      byte-lane width (8 or 9)
//   BE_WIDTH       derived lane count, leave at default
//   OUTPUT_REG     1 adds an output register (read latency 2), 0 gives latency 1
//   COLLISION_MODE "READ_FIRST" or "WRITE_THROUGH"
//
// Ports
//   clk         rising-edge clock for all logic
//   rst         asynchronous active-high reset of control/output registers
//   wr_en       write strobe
//   wr_addr     write address
//   wr_data     write data
//   wr_byte_en  lane enables, bit i covers wr_data[i*BYTE_SIZE +: BYTE_SIZE]
//   rd_en       read strobe
//   rd_addr     read address
//   rd_data     read data, held while no read completes
//   rd_valid    one-cycle pulse when rd_data carries a completed read
// -----------------------------------------------------------------------------
module drm_sdpram_be #(
    parameter int    ADDR_WIDTH     = 12,
    parameter int    DATA_WIDTH     = 8,
    parameter int    BYTE_SIZE      = 8,
    parameter int    BE_WIDTH       = DATA_WIDTH / BYTE_SIZE,
    parameter int    OUTPUT_REG     = 0,
    parameter string COLLISION_MODE = "READ_FIRST"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [BE_WIDTH-1:0]   wr_byte_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam int DEPTH        = 1 << ADDR_WIDTH;
    localparam bit WRITE_THROUGH = (COLLISION_MODE == "WRITE_THROUGH");

    // Storage array: deliberately not reset so contents survive rst.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < BE_WIDTH; i++) begin
                if (wr_byte_en[i]) begin
                    r_mem[wr_addr][i*BYTE_SIZE +: BYTE_SIZE] <= wr_data[i*BYTE_SIZE +: BYTE_SIZE];
                end
            end
        end
    end

    // Stage 1: raw array word plus the forwarding information captured with
    // the same read, so the merge below lines up with the registered word.
    // In READ_FIRST mode the forward lane mask is forced to zero and the
    // merge collapses to the raw pre-write word.
    logic                  r_v1;
    logic [DATA_WIDTH-1:0] r_d1;
    logic [BE_WIDTH-1:0]   r_fwd_be;
    logic [DATA_WIDTH-1:0] r_fwd_data;
    logic                  w_collide;
    logic [DATA_WIDTH-1:0] w_d1;

    assign w_collide = WRITE_THROUGH && wr_en && (wr_addr == rd_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1       <= 1'b0;
            r_d1       <= '0;
            r_fwd_be   <= '0;
            r_fwd_data <= '0;
        end else begin
            r_v1 <= rd_en;
            if (rd_en) begin
                r_d1       <= r_mem[rd_addr];
                r_fwd_be   <= w_collide ? wr_byte_en : '0;
                r_fwd_data <= wr_data;
            end
        end
    end

    always_comb begin
        w_d1 = r_d1;
        for (int unsigned i = 0; i < BE_WIDTH; i++) begin
            if (r_fwd_be[i]) begin
                w_d1[i*BYTE_SIZE +: BYTE_SIZE] = r_fwd_data[i*BYTE_SIZE +: BYTE_SIZE];
            end
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            logic                  r_v2;
            logic [DATA_WIDTH-1:0] r_d2;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_v2 <= 1'b0;
                    r_d2 <= '0;
                end else begin
                    r_v2 <= r_v1;
                    if (r_v1) begin
                        r_d2 <= w_d1;
                    end
                end
            end

            assign rd_data  = r_d2;
            assign rd_valid = r_v2;
        end else begin : g_no_out_reg
            // Stage-1 registers only load on a read, so w_d1 already holds.
            assign rd_data  = w_d1;
            assign rd_valid = r_v1;
        end
    endgenerate

endmodule

// File: tb/tb_drm_sdpram_be.sv
// -----------------------------------------------------------------------------
// tb_drm_sdpram_be
//   Two instances driven by identical stimulus:
//     u_a : OUTPUT_REG=0, READ_FIRST
//     u_b : OUTPUT_REG=1, WRITE_THROUGH
//   A reference model (word array plus scheduled read results) predicts
//   rd_valid/rd_data of both every cycle; directed checks cover the named
//   scenarios with literal expected values.
// -----------------------------------------------------------------------------
module tb_drm_sdpram_be;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int NW = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [3:0]    wr_byte_en = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;

    logic [DW-1:0] a_data, b_data;
    logic          a_vld, b_vld;

    always #5 clk = ~clk;

    drm_sdpram_be #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SIZE(8),
        .OUTPUT_REG(0), .COLLISION_MODE("READ_FIRST")
    ) u_a (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_byte_en(wr_byte_en),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(a_data), .rd_valid(a_vld)
    );

    drm_sdpram_be #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTE_SIZE(8),
        .OUTPUT_REG(1), .COLLISION_MODE("WRITE_THROUGH")
    ) u_b (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_byte_en(wr_byte_en),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(b_data), .rd_valid(b_vld)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [31:0] d;
    } rd_t;

    logic [31:0] m_mem [NW];
    rd_t         qa[$];
    rd_t         qb[$];
    int          cyc_n = 0;
    logic        ea_v = 1'b0, eb_v = 1'b0;
    logic [31:0] ea_d = '0, eb_d = '0;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        return r;
    endfunction

    task automatic model_clear();
        qa.delete();
        qb.delete();
        ea_v = 1'b0; eb_v = 1'b0;
        ea_d = '0;   eb_d = '0;
    endtask

    always @(posedge rst) model_clear();

    always @(posedge clk) begin
        rd_t         t;
        logic [31:0] old_w;
        cyc_n++;
        if (rst) begin
            model_clear();
        end else begin
            if (rd_en) begin
                old_w = m_mem[rd_addr];
                // latency 1, pre-write word
                qa.push_back('{cyc_n, old_w});
                // latency 2, enabled lanes of a same-address write forwarded
                if (wr_en && wr_addr == rd_addr)
                    qb.push_back('{cyc_n + 1, merge(old_w, wr_data, wr_byte_en)});
                else
                    qb.push_back('{cyc_n + 1, old_w});
            end
            if (wr_en) m_mem[wr_addr] = merge(m_mem[wr_addr], wr_data, wr_byte_en);

            ea_v = 1'b0;
            if (qa.size() > 0 && qa[0].due == cyc_n) begin
                t = qa.pop_front();
                ea_v = 1'b1;
                ea_d = t.d;
            end
            eb_v = 1'b0;
            if (qb.size() > 0 && qb[0].due == cyc_n) begin
                t = qb.pop_front();
                eb_v = 1'b1;
                eb_d = t.d;
            end
        end
    end

    // ---------------- continuous comparison ----------------
    logic chk_on = 1'b0;
    int   na = 0, nb = 0;

    always @(negedge clk) begin
        if (chk_on) begin
            chk("a_valid", 32'(a_vld), 32'(ea_v));
            chk("a_data",  a_data,     ea_d);
            chk("b_valid", 32'(b_vld), 32'(eb_v));
            chk("b_data",  b_data,     eb_d);
            if (a_vld) na++;
            if (b_vld) nb++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic re, input logic [AW-1:0] ra);
        wr_en = we; wr_addr = wa; wr_data = wd; wr_byte_en = be;
        rd_en = re; rd_addr = ra;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        int na0, nb0;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_a_data",  a_data,     32'h0);
        chk("rst_a_valid", 32'(a_vld), 32'h0);
        chk("rst_b_data",  b_data,     32'h0);
        chk("rst_b_valid", 32'(b_vld), 32'h0);
        rst = 1'b0;
        chk_on = 1'b1;

        // fill every word with its own address
        for (int a = 0; a < NW; a++) cyc(1'b1, AW'(a), 32'(a), 4'hF, 1'b0, '0);

        // back-to-back sweep 0..max then 0
        na0 = na; nb0 = nb;
        for (int a = 0; a < NW; a++) cyc(1'b0, '0, '0, '0, 1'b1, AW'(a));
        cyc(1'b0, '0, '0, '0, 1'b1, '0);
        idle(3);
        chk("sweep_a_count", 32'(na - na0), 32'(NW + 1));
        chk("sweep_b_count", 32'(nb - nb0), 32'(NW + 1));

        // basic write then read
        cyc(1'b1, 12'h123, 32'hDEADBEEF, 4'hF, 1'b0, '0);
        cyc(1'b0, '0, '0, '0, 1'b1, 12'h123);
        chk("basic_a_valid", 32'(a_vld), 32'h1);
        chk("basic_a_data",  a_data,     32'hDEADBEEF);
        chk("basic_b_early", 32'(b_vld), 32'h0);
        idle(1);
        chk("basic_b_valid", 32'(b_vld), 32'h1);
        chk("basic_b_data",  b_data,     32'hDEADBEEF);
        chk("basic_a_drop",  32'(a_vld), 32'h0);

        // byte enables
        cyc(1'b1, 12'h005, 32'h11223344, 4'hF,    1'b0, '0);
        cyc(1'b1, 12'h005, 32'hAABBCCDD, 4'b0101, 1'b0, '0);
        cyc(1'b0, '0, '0, '0, 1'b1, 12'h005);
        chk("be_a_data", a_data, 32'h11BB33DD);
        idle(1);
        chk("be_b_data", b_data, 32'h11BB33DD);
        cyc(1'b1, 12'h005, 32'h99999999, 4'b0000, 1'b0, '0);
        cyc(1'b0, '0, '0, '0, 1'b1, 12'h005);
        chk("be0_a_data", a_data, 32'h11BB33DD);
        idle(1);
        chk("be0_b_data", b_data, 32'h11BB33DD);

        // same-address collision
        cyc(1'b1, 12'h040, 32'h00000000, 4'hF, 1'b0, '0);
        cyc(1'b1, 12'h040, 32'hFFFFFFFF, 4'b0011, 1'b1, 12'h040);
        chk("coll_rf_data", a_data, 32'h00000000);
        idle(1);
        chk("coll_wt_data", b_data, 32'h0000FFFF);
        cyc(1'b0, '0, '0, '0, 1'b1, 12'h040);
        chk("coll_next_a", a_data, 32'h0000FFFF);
        idle(1);
        chk("coll_next_b", b_data, 32'h0000FFFF);

        // hold after a single read
        cyc(1'b1, 12'h007, 32'h0000005A, 4'hF, 1'b0, '0);
        cyc(1'b0, '0, '0, '0, 1'b1, 12'h007);
        idle(1);
        for (int i = 0; i < 10; i++) begin
            idle(1);
            chk("hold_a_valid", 32'(a_vld), 32'h0);
            chk("hold_a_data",  a_data,     32'h0000005A);
            chk("hold_b_valid", 32'(b_vld), 32'h0);
            chk("hold_b_data",  b_data,     32'h0000005A);
        end

        // random traffic on a narrow window to provoke collisions
        for (int i = 0; i < 3000; i++) begin
            logic [AW-1:0] wa, ra;
            wa = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            ra = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            cyc(1'($urandom), wa, $urandom, 4'($urandom), 1'($urandom_range(0, 2) != 0), ra);
        end
        idle(3);

        // asynchronous reset with reads in flight
        cyc(1'b1, 12'h010, 32'h0BADF00D, 4'hF, 1'b0, '0);
        cyc(1'b0, '0, '0, '0, 1'b1, 12'h010);
        rd_en = 1'b1; rd_addr = 12'h010;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_a_data",  a_data,     32'h0);
        chk("arst_a_valid", 32'(a_vld), 32'h0);
        chk("arst_b_data",  b_data,     32'h0);
        chk("arst_b_valid", 32'(b_vld), 32'h0);
        rd_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        na0 = na; nb0 = nb;
        rst = 1'b0;
        idle(5);
        chk("arst_no_pulse_a", 32'(na - na0), 32'h0);
        chk("arst_no_pulse_b", 32'(nb - nb0), 32'h0);
        cyc(1'b0, '0, '0, '0, 1'b1, 12'h010);
        chk("arst_keep_a", a_data, 32'h0BADF00D);
        idle(1);
        chk("arst_keep_b", b_data, 32'h0BADF00D);
        idle(2);

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
